// File: rtl/rot_enc_pkg.sv
// rtl/rot_enc_pkg.sv - shared types, CW sequence and quadrature decode for the rotary encoder front end
package rot_enc_pkg;

    // Decoder FSM: INIT while synchronisers and filters settle, TRACK afterwards
    typedef enum logic {
        INIT  = 1'b0,
        TRACK = 1'b1
    } enc_state_e;

    // Outcome of comparing two consecutive filtered {A,B} samples
    typedef enum logic [1:0] {
        QD_NONE    = 2'd0,
        QD_CW      = 2'd1,
        QD_CCW     = 2'd2,
        QD_ILLEGAL = 2'd3
    } quad_ev_e;

    // Clockwise {A,B} sequence: 00 -> 01 -> 11 -> 10 -> 00
    localparam logic [1:0] CW_S0 = 2'b00;
    localparam logic [1:0] CW_S1 = 2'b01;
    localparam logic [1:0] CW_S2 = 2'b11;
    localparam logic [1:0] CW_S3 = 2'b10;

    // Position of an {A,B} code within the clockwise cycle
    function automatic logic [1:0] quad_index(input logic [1:0] ab);
        logic [1:0] idx;
        case (ab)
            CW_S0:   idx = 2'd0;
            CW_S1:   idx = 2'd1;
            CW_S2:   idx = 2'd2;
            CW_S3:   idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Forward one position is CW, back one is CCW, two apart means both bits moved
    function automatic quad_ev_e quad_decode(input logic [1:0] prev_ab,
                                             input logic [1:0] cur_ab);
        logic [1:0] diff;
        quad_ev_e   ev;
        diff = quad_index(cur_ab) - quad_index(prev_ab);
        case (diff)
            2'd0:    ev = QD_NONE;
            2'd1:    ev = QD_CW;
            2'd3:    ev = QD_CCW;
            default: ev = QD_ILLEGAL;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/rot_enc_debounce.sv
// rtl/rot_enc_debounce.sv - per-pin synchroniser chain followed by a stable-count debounce filter
module rot_enc_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic pin_raw,
    input  logic init_load,
    output logic sync_level,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   level_q;
    logic                   level_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;

    assign sync_level = sync_q[SYNC_STAGES-1];
    assign level      = level_q;

    // Shift the raw pin through the synchroniser chain
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], pin_raw};
    end

    // Count consecutive disagreeing cycles; flip the level on the last one, otherwise track directly during init
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (init_load) begin
            level_d = sync_level;
        end else if (sync_level != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchroniser, filtered level and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/rot_enc_decoder.sv
// rtl/rot_enc_decoder.sv - debounced quadrature decode into position, step, switch and error outputs
module rot_enc_decoder
    import rot_enc_pkg::*;
#(
    parameter int CNT_WIDTH       = 16,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGES_PER_STEP  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enc_a,
    input  logic                 enc_b,
    input  logic                 enc_sw,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] position,
    output logic                 dir,
    output logic                 step_pulse,
    output logic                 sw_level,
    output logic                 sw_press,
    output logic                 err_pulse,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int INIT_CYCLES = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int INIT_W      = $clog2(INIT_CYCLES + 1);

    localparam logic signed [3:0] STEP_POS = 4'(EDGES_PER_STEP);
    localparam logic signed [3:0] STEP_NEG = -STEP_POS;

    enc_state_e           state_q, state_d;
    logic [INIT_W-1:0]    init_cnt_q, init_cnt_d;
    logic [1:0]           prev_ab_q, prev_ab_d;
    logic                 prev_sw_q, prev_sw_d;
    logic signed [3:0]    acc_q, acc_d;
    logic [CNT_WIDTH-1:0] position_q, position_d;
    logic                 dir_q, dir_d;
    logic                 step_pulse_q, step_pulse_d;
    logic                 sw_press_q, sw_press_d;
    logic                 err_pulse_q, err_pulse_d;
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;

    logic                 a_sync, b_sync, sw_sync;
    logic                 a_filt, b_filt, sw_filt;
    logic                 init_load;
    logic [1:0]           cur_ab;
    logic [1:0]           sync_ab;
    quad_ev_e             quad_ev;
    logic signed [3:0]    acc_sum;

    assign init_load = (state_q == INIT);
    assign cur_ab    = {a_filt, b_filt};
    assign sync_ab   = {a_sync, b_sync};

    rot_enc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_a (
        .clock      (clock),
        .reset      (reset),
        .pin_raw    (enc_a),
        .init_load  (init_load),
        .sync_level (a_sync),
        .level      (a_filt)
    );

    rot_enc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_b (
        .clock      (clock),
        .reset      (reset),
        .pin_raw    (enc_b),
        .init_load  (init_load),
        .sync_level (b_sync),
        .level      (b_filt)
    );

    rot_enc_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db_sw (
        .clock      (clock),
        .reset      (reset),
        .pin_raw    (enc_sw),
        .init_load  (init_load),
        .sync_level (sw_sync),
        .level      (sw_filt)
    );

    // Next state, accumulator, counters and pulses; clr is applied last so it overrides any event
    always_comb begin
        state_d      = state_q;
        init_cnt_d   = init_cnt_q;
        prev_ab_d    = cur_ab;
        prev_sw_d    = sw_filt;
        acc_d        = acc_q;
        position_d   = position_q;
        dir_d        = dir_q;
        err_count_d  = err_count_q;
        step_pulse_d = 1'b0;
        err_pulse_d  = 1'b0;
        sw_press_d   = 1'b0;
        acc_sum      = acc_q;
        quad_ev      = quad_decode(prev_ab_q, cur_ab);

        case (state_q)
            INIT: begin
                // Filters load the synchronised value this cycle; keep the history
                // equal to it so the first TRACK comparison sees no edge.
                prev_ab_d = sync_ab;
                prev_sw_d = sw_sync;
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d    = TRACK;
                    init_cnt_d = '0;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                end
            end
            TRACK: begin
                sw_press_d = sw_filt & ~prev_sw_q;
                case (quad_ev)
                    QD_CW:   acc_sum = acc_q + 4'sd1;
                    QD_CCW:  acc_sum = acc_q - 4'sd1;
                    QD_ILLEGAL: begin
                        acc_sum     = '0;
                        err_pulse_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                    end
                    default: acc_sum = acc_q;
                endcase
                acc_d = acc_sum;
                if (acc_sum == STEP_POS) begin
                    position_d   = position_q + 1'b1;
                    dir_d        = 1'b1;
                    step_pulse_d = 1'b1;
                    acc_d        = '0;
                end else if (acc_sum == STEP_NEG) begin
                    position_d   = position_q - 1'b1;
                    dir_d        = 1'b0;
                    step_pulse_d = 1'b1;
                    acc_d        = '0;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase

        if (clr) begin
            position_d   = '0;
            err_count_d  = '0;
            acc_d        = '0;
            dir_d        = dir_q;
            step_pulse_d = 1'b0;
            err_pulse_d  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= INIT;
            init_cnt_q   <= '0;
            prev_ab_q    <= '0;
            prev_sw_q    <= 1'b0;
            acc_q        <= '0;
            position_q   <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            sw_press_q   <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            init_cnt_q   <= init_cnt_d;
            prev_ab_q    <= prev_ab_d;
            prev_sw_q    <= prev_sw_d;
            acc_q        <= acc_d;
            position_q   <= position_d;
            dir_q        <= dir_d;
            step_pulse_q <= step_pulse_d;
            sw_press_q   <= sw_press_d;
            err_pulse_q  <= err_pulse_d;
            err_count_q  <= err_count_d;
        end
    end

    assign position   = position_q;
    assign dir        = dir_q;
    assign step_pulse = step_pulse_q;
    assign sw_level   = sw_filt;
    assign sw_press   = sw_press_q;
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_rot_enc_decoder.sv
// tb/tb_rot_enc_decoder.sv - directed table, corner sequences and random walk against an intent-level model
module tb_rot_enc_decoder;
    import rot_enc_pkg::*;

    localparam int SS = 2;
    localparam int DB = 4;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enc_a  = 1'b0;
    logic enc_b  = 1'b0;
    logic enc_sw = 1'b0;
    logic clr    = 1'b0;

    logic [15:0] position16, err_count16;
    logic        dir16, step16, swl16, press16, errp16;
    logic [3:0]  position4, err_count4;
    logic        dir4, step4, swl4, press4, errp4;

    always #5 clock = ~clock;

    rot_enc_decoder #(.CNT_WIDTH(16), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .EDGES_PER_STEP(4)) dut16 (
        .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw), .clr(clr),
        .position(position16), .dir(dir16), .step_pulse(step16), .sw_level(swl16),
        .sw_press(press16), .err_pulse(errp16), .err_count(err_count16));

    rot_enc_decoder #(.CNT_WIDTH(4), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB), .EDGES_PER_STEP(4)) dut4 (
        .clock(clock), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .enc_sw(enc_sw), .clr(clr),
        .position(position4), .dir(dir4), .step_pulse(step4), .sw_level(swl4),
        .sw_press(press4), .err_pulse(errp4), .err_count(err_count4));

    int n_checks = 0;
    int n_fail   = 0;

    // pulse counters sampled on the falling edge
    int n_step16 = 0, n_step4 = 0, n_err16 = 0, n_err4 = 0, n_press16 = 0, n_press4 = 0;
    int b_step16, b_step4, b_err16, b_err4, b_press16, b_press4;

    always @(negedge clock) begin
        if (step16)  n_step16++;
        if (step4)   n_step4++;
        if (errp16)  n_err16++;
        if (errp4)   n_err4++;
        if (press16) n_press16++;
        if (press4)  n_press4++;
    end

    // intent-level model: current index on the CW cycle and what has been counted
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    int m_idx, m_acc, m_pos, m_err, m_steps, m_errs, m_presses;
    logic m_dir, m_swl;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_ab(input logic [1:0] ab);
        enc_a = ab[1];
        enc_b = ab[0];
    endtask

    task automatic snap_base();
        b_step16 = n_step16; b_step4 = n_step4;
        b_err16  = n_err16;  b_err4  = n_err4;
        b_press16 = n_press16; b_press4 = n_press4;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_ab(2'b00);
        enc_sw = 1'b0;
        clr = 1'b0;
        tick(4);
        reset = 1'b0;
        tick(SS + DB + 4);
        snap_base();
        m_idx = 0; m_acc = 0; m_pos = 0; m_err = 0;
        m_steps = 0; m_errs = 0; m_presses = 0;
        m_dir = 1'b0; m_swl = 1'b0;
    endtask

    // op: +1 CW edge, -1 CCW edge, 2 both-bits jump; pins are driven, hold is left to the caller
    task automatic model_move(input int op);
        if (op == 2) begin
            m_idx = (m_idx + 2) % 4;
            m_err++;
            m_errs++;
            m_acc = 0;
        end else begin
            m_idx = (m_idx + op + 4) % 4;
            m_acc += op;
            if (m_acc == 4 || m_acc == -4) begin
                m_pos += (m_acc > 0) ? 1 : -1;
                m_dir = (m_acc > 0);
                m_steps++;
                m_acc = 0;
            end
        end
        set_ab(seq[m_idx]);
    endtask

    task automatic check_all(input string tag);
        chk({tag, " pos16"},   position16, m_pos & 32'hFFFF);
        chk({tag, " pos4"},    position4,  m_pos & 32'hF);
        chk({tag, " err16"},   err_count16, (m_err > 65535) ? 65535 : m_err);
        chk({tag, " err4"},    err_count4,  (m_err > 15) ? 15 : m_err);
        chk({tag, " dir16"},   dir16, m_dir);
        chk({tag, " dir4"},    dir4,  m_dir);
        chk({tag, " swl"},     swl16, m_swl);
        chk({tag, " steps16"}, n_step16 - b_step16, m_steps);
        chk({tag, " steps4"},  n_step4 - b_step4,   m_steps);
        chk({tag, " errp16"},  n_err16 - b_err16,   m_errs);
        chk({tag, " errp4"},   n_err4 - b_err4,     m_errs);
        chk({tag, " press"},   n_press16 - b_press16, m_presses);
    endtask

    typedef struct {
        logic [1:0]  ab;
        logic        sw;
        int          glitch;   // 0 none, 1 pulse on A, 2 pulse on switch
        int          glen;
        logic        do_clr;
        logic [15:0] e_pos;
        logic        e_dir;
        int          e_err;
        logic        e_swl;
        int          e_steps;
        int          e_errp;
        int          e_press;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [1:0] ab, input logic sw, input int glitch, input int glen,
                                input logic do_clr, input logic [15:0] e_pos, input logic e_dir,
                                input int e_err, input logic e_swl, input int e_steps,
                                input int e_errp, input int e_press);
        vec_t v;
        v.ab = ab; v.sw = sw; v.glitch = glitch; v.glen = glen; v.do_clr = do_clr;
        v.e_pos = e_pos; v.e_dir = e_dir; v.e_err = e_err; v.e_swl = e_swl;
        v.e_steps = e_steps; v.e_errp = e_errp; v.e_press = e_press;
        return v;
    endfunction

    initial begin
        int lat;
        int sbase;
        int op;
        vec_t v;

        //            ab     sw gl len clr pos       dir err swl st ep pr
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 16'h0001, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 1, 16'h0000, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 16'h0000, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 2, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(2'b10, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(2'b01, 0, 0, 0, 0, 16'hFFFE, 0, 0, 0, 3, 0, 0));
        tbl.push_back(mk(2'b00, 0, 0, 0, 0, 16'hFFFD, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(2'b00, 0, 1, 2, 0, 16'hFFFD, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(2'b00, 0, 2, 3, 0, 16'hFFFD, 0, 0, 0, 4, 0, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'hFFFD, 0, 1, 0, 4, 1, 0));
        tbl.push_back(mk(2'b11, 0, 0, 0, 1, 16'h0000, 0, 0, 0, 4, 1, 0));
        tbl.push_back(mk(2'b11, 1, 0, 0, 0, 16'h0000, 0, 0, 1, 4, 1, 1));
        tbl.push_back(mk(2'b11, 0, 0, 0, 0, 16'h0000, 0, 0, 0, 4, 1, 1));

        // reset with A=B=1: reset values, INIT length, then quiet
        reset = 1'b1;
        set_ab(2'b11);
        tick(3);
        chk("rst pos", position16, 0);
        chk("rst dir", dir16, 0);
        chk("rst step", step16, 0);
        chk("rst swl", swl16, 0);
        chk("rst press", press16, 0);
        chk("rst errp", errp16, 0);
        chk("rst err", err_count16, 0);
        snap_base();
        reset = 1'b0;
        tick(5);
        chk("init held", 32'(dut16.state_q), 32'(INIT));
        tick(1);
        chk("init to track", 32'(dut16.state_q), 32'(TRACK));
        tick(14);
        chk("quiet pos", position16, 0);
        chk("quiet steps", n_step16 - b_step16, 0);
        chk("quiet errs", n_err16 - b_err16, 0);
        chk("quiet press", n_press16 - b_press16, 0);

        // directed table
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.glitch == 1) begin
                enc_a = ~enc_a; tick(v.glen); enc_a = ~enc_a;
            end else if (v.glitch == 2) begin
                enc_sw = ~enc_sw; tick(v.glen); enc_sw = ~enc_sw;
            end
            set_ab(v.ab);
            enc_sw = v.sw;
            tick(10);
            if (v.do_clr) begin
                clr = 1'b1; tick(1); clr = 1'b0; tick(1);
            end
            chk($sformatf("vec%0d pos16", i), position16, v.e_pos);
            chk($sformatf("vec%0d pos4", i), position4, v.e_pos[3:0]);
            chk($sformatf("vec%0d dir", i), dir16, v.e_dir);
            chk($sformatf("vec%0d err16", i), err_count16, v.e_err);
            chk($sformatf("vec%0d err4", i), err_count4, v.e_err);
            chk($sformatf("vec%0d swl", i), swl16, v.e_swl);
            chk($sformatf("vec%0d steps", i), n_step16 - b_step16, v.e_steps);
            chk($sformatf("vec%0d errp", i), n_err16 - b_err16, v.e_errp);
            chk($sformatf("vec%0d press", i), n_press16 - b_press16, v.e_press);
        end

        // 4-bit wrap: 7 CW detents then one more; first detent also times the step latency
        do_reset();
        for (int d = 0; d < 8; d++) begin
            for (int e = 0; e < 4; e++) begin
                model_move(1);
                if (d == 0 && e == 3) begin
                    lat = -1;
                    for (int k = 1; k <= 20; k++) begin
                        tick(1);
                        if (step16) begin
                            lat = k;
                            break;
                        end
                    end
                    chk("step latency", lat, SS + DB + 1);
                    tick(1);
                    chk("step width", step16, 0);
                    tick(8);
                end else begin
                    tick(10);
                end
            end
            if (d == 6) chk("pos4 at +7", position4, 4'h7);
        end
        chk("pos4 wrapped", position4, 4'h8);
        chk("pos16 not wrapped", position16, 16'h0008);
        check_all("wrap");

        // clr on the same cycle the completing step would register
        model_move(1); tick(10);
        model_move(1); tick(10);
        model_move(1); tick(10);
        sbase = n_step16;
        set_ab(2'b00);
        tick(SS + DB);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tick(10);
        m_idx = 0; m_pos = 0; m_err = 0; m_acc = 0;
        chk("clr+step no pulse", n_step16 - sbase, 0);
        chk("clr+step pos", position16, 0);
        check_all("clr_step");

        // random walk
        for (int it = 0; it < 150; it++) begin
            op = $urandom_range(0, 99);
            if (op < 35) begin
                model_move(1);
            end else if (op < 70) begin
                model_move(-1);
            end else if (op < 78) begin
                model_move(2);
            end else if (op < 86) begin
                enc_sw = ~enc_sw;
                m_swl = enc_sw;
                if (m_swl) m_presses++;
            end else if (op < 93) begin
                case ($urandom_range(0, 2))
                    0: begin enc_a = ~enc_a; tick($urandom_range(1, 3)); enc_a = ~enc_a; end
                    1: begin enc_b = ~enc_b; tick($urandom_range(1, 3)); enc_b = ~enc_b; end
                    default: begin enc_sw = ~enc_sw; tick($urandom_range(1, 3)); enc_sw = ~enc_sw; end
                endcase
            end else begin
                clr = 1'b1; tick(1); clr = 1'b0;
                m_pos = 0; m_err = 0; m_acc = 0;
            end
            tick($urandom_range(10, 14));
            check_all($sformatf("rnd%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/rot_enc_decoder.md
# rot_enc_decoder

Front-end stage of the rotary-encoder IP. It synchronises and debounces the raw encoder pins (A, B, push switch) and decodes the quadrature sequence into a signed position count, step/direction events, switch events and an illegal-transition count. All outputs are plain registered levels and pulses that feed directly into the AXI4-Lite register file of the encoder IP; there is no bus logic in this block.

## Interface
- `CNT_WIDTH`, 16: width of the signed position counter and of `err_count`.
- `SYNC_STAGES`, 2: flip-flop synchroniser depth per pin, minimum 2.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required to accept a new pin level, minimum 1.
- `EDGES_PER_STEP`, 4: valid quadrature edges per counted step; legal values 1, 2, 4.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `enc_a` in 1: raw encoder channel A, asynchronous.
- `enc_b` in 1: raw encoder channel B, asynchronous.
- `enc_sw` in 1: raw push switch, asynchronous, 1 = pressed.
- `clr` in 1: one-cycle pulse from the register file; clears `position` and `err_count`.
- `position` out CNT_WIDTH: signed step count.
- `dir` out 1: direction of the last step; 1 = CW, 0 = CCW.
- `step_pulse` out 1: one-cycle pulse per counted step.
- `sw_level` out 1: debounced switch level.
- `sw_press` out 1: one-cycle pulse on a debounced 0→1 switch edge.
- `err_pulse` out 1: one-cycle pulse on an illegal A/B transition.
- `err_count` out CNT_WIDTH: illegal transitions, saturating at all-ones.

## Operation
- **Synchroniser.** Each pin passes through its own `SYNC_STAGES` flip-flop chain.
- **Debounce.** Each pin has a filtered level register and a counter.
  - Synchronised value equal to the filtered level: counter is reset to 0.
  - Synchronised value different: the counter increments. On reaching `DEBOUNCE_CYCLES`, the filtered level flips and the counter is cleared.
- **FSM state INIT.**
  - Entered on reset and held for `SYNC_STAGES + DEBOUNCE_CYCLES` cycles.
  - Filtered levels load directly from the synchronised values every cycle.
  - No pulses, no counting.
  - Then moves to TRACK.
- **FSM state TRACK.** The previous and current filtered {A,B} are compared each cycle.
  - CW sequence is 00→01→11→10→00; each CW edge adds +1 to a sub-step accumulator.
  - Each reverse edge adds −1.
  - No change: no action.
  - Both bits change: illegal. `err_pulse` fires, `err_count` increments (saturating), and the accumulator clears.
- **Step generation.** When the accumulator reaches +`EDGES_PER_STEP`:
  - `position` increments, `dir` = 1, `step_pulse` fires, accumulator = 0.
  - At −`EDGES_PER_STEP` the same happens with `position` decrementing and `dir` = 0.
  - Accumulator width is 4 bits, signed.
- **Position arithmetic.** Two's-complement wrap: max + 1 → min, min − 1 → max.
- **clr.**
  - Zeroes `position`, `err_count` and the accumulator.
  - Wins over a simultaneous step or error: that event is dropped and its pulse is suppressed.
  - `dir` and `sw_level` are unaffected.
- **Switch.** `sw_level` is the filtered level. `sw_press` fires on the filtered 0→1 edge in TRACK only; there is no pulse on release.
- **Reset.** Reset asserted at any time, including mid-debounce, returns to INIT.
- **Reset values.**
  - Outputs: `position` 0, `dir` 0, `step_pulse` 0, `sw_level` 0, `sw_press` 0, `err_pulse` 0, `err_count` 0.
  - Internal: all counters and the accumulator 0, filtered levels 0.

## Timing
- Pin change to filtered-level change: `SYNC_STAGES + DEBOUNCE_CYCLES` cycles, plus 0–1 cycle of asynchronous sampling uncertainty.
- Filtered edge to registered `position`/`step_pulse`/`err_pulse`/`sw_press`: 1 cycle.
- All pulses are exactly 1 cycle wide. At most one step per cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles (after synchronisation) produces no output change.
- `clr` takes effect on the following edge.

## Structure
- A shared package `rot_enc_pkg` holds:
  - the FSM state enum (INIT, TRACK);
  - the quadrature decode function mapping {prev AB, cur AB} to −1/0/+1/illegal;
  - the CW sequence constants.
- Sub-module `rot_enc_debounce` contains one synchroniser plus debounce filter, parameterised by `SYNC_STAGES` and `DEBOUNCE_CYCLES`. It is instantiated three times.

## Test plan
All cases use `DEBOUNCE_CYCLES` = 4 and `SYNC_STAGES` = 2; each pin state is held 10 cycles.
- Reset with A=B=1 held for 20 cycles → `position` 0, no pulses at any time, state reaches TRACK after 6 cycles.
- One full CW detent 00→01→11→10→00 with `EDGES_PER_STEP` = 4 → exactly one `step_pulse`, `position` = 1, `dir` = 1.
- Three CCW detents from 0 → `position` = 0xFFFD (−3), `dir` = 0, three `step_pulse`s.
- 2-cycle glitch on A, and separately a 3-cycle glitch on `enc_sw` → no `position`, `err`, or `sw_press` change.
- Illegal jump 00→11 → one `err_pulse`, `err_count` = 1, `position` unchanged. Then `clr` → `err_count` = 0.
- `CNT_WIDTH` = 4, preload +7 via 7 CW steps, then 1 more CW step → `position` = 0x8 (−8).
- `clr` coincident with a step edge → `position` = 0 and no `step_pulse`.
- Switch press held 10 cycles → one `sw_press` and `sw_level` = 1; release → no pulse.
